// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and a selectable standard or first-word-fall-through read port.
module fifo_sync_param #(
  parameter int FIFO_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 16,
  parameter int ALMOST_FULL_TH  = 12,
  parameter int ALMOST_EMPTY_TH = 4,
  parameter int FWFT            = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write_en,
  input  logic                          read_en,
  input  logic [FIFO_WIDTH-1:0]         data_in,
  output logic [FIFO_WIDTH-1:0]         data_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AW:0] AF_C    = CW'(ALMOST_FULL_TH);
  localparam logic [AW:0] AE_C    = CW'(ALMOST_EMPTY_TH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_d;
  logic        full_q, empty_q, almost_full_q, almost_empty_q;
  logic        overflow_q, underflow_q;
  logic        push_ok, pop_ok;
  logic [AW-1:0] rd_addr;

  // A write into a full FIFO is still accepted when a pop frees the head slot in the same cycle.
  always_comb begin
    push_ok  = write_en & (~full_q | read_en);
    pop_ok   = read_en & ~empty_q;
    wr_ptr_d = wr_ptr_q + CW'(push_ok);
    rd_ptr_d = rd_ptr_q + CW'(pop_ok);
    count_d  = wr_ptr_d - rd_ptr_d;
  end

  assign rd_addr = rd_ptr_q[AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      full_q         <= (count_d == DEPTH_C);
      empty_q        <= (count_d == '0);
      almost_full_q  <= (count_d >= AF_C);
      almost_empty_q <= (count_d <= AE_C);
      overflow_q     <= write_en & ~push_ok;
      underflow_q    <= read_en & ~pop_ok;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q[AW-1:0]] <= data_in;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [FIFO_WIDTH-1:0] data_out_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_out_q <= '0;
        end else if (pop_ok) begin
          data_out_q <= mem[rd_addr];
        end
      end

      assign data_out = data_out_q;
    end else begin : g_fwft
      assign data_out = empty_q ? '0 : mem[rd_addr];
    end
  endgenerate

  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a standard-read and an FWFT instance share one
// stimulus stream; a vector table covers fill/drain, hand sequences cover the corners.
module tb_fifo_sync_param;

  typedef struct {
    logic        we;
    logic        re;
    logic [7:0]  din;
    logic [18:0] exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       writeEn;
  logic       readEn;
  logic [7:0] dataIn;

  logic [7:0] dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] count0, count1;
  logic [18:0] obs0, obs1;

  int vecCount  = 0;
  int missCount = 0;

  vec_t vecs[$];
  logic [7:0] model[$];

  fifo_sync_param #(.FIFO_WIDTH(8), .FIFO_DEPTH(16), .ALMOST_FULL_TH(12),
                    .ALMOST_EMPTY_TH(4), .FWFT(0)) dutStd (
    .clk(clk), .reset(reset), .write_en(writeEn), .read_en(readEn), .data_in(dataIn),
    .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0)
  );

  fifo_sync_param #(.FIFO_WIDTH(8), .FIFO_DEPTH(16), .ALMOST_FULL_TH(12),
                    .ALMOST_EMPTY_TH(4), .FWFT(1)) dutFwft (
    .clk(clk), .reset(reset), .write_en(writeEn), .read_en(readEn), .data_in(dataIn),
    .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1)
  );

  assign obs0 = {count0, full0, empty0, af0, ae0, ovf0, unf0, dout0};
  assign obs1 = {count1, full1, empty1, af1, ae1, ovf1, unf1, dout1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] mk(int cnt, bit f, bit e, bit af, bit ae,
                                     bit o, bit u, logic [7:0] d);
    return {5'(cnt), f, e, af, ae, o, u, d};
  endfunction

  task automatic applyStimulus(input logic we, input logic re, input logic [7:0] d);
    writeEn = we;
    readEn  = re;
    dataIn  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    writeEn = 1'b0;
    readEn  = 1'b0;
    dataIn  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    checkOutput("reset_std", obs0, mk(0, 0, 1, 0, 1, 0, 0, 8'h00));
    checkOutput("reset_fwft", obs1, mk(0, 0, 1, 0, 1, 0, 0, 8'h00));

    // Reset mid-burst, after a pop has left a nonzero word on the standard port
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'h11 + 8'(i));
    checkOutput("burst_count", count0, 5);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("burst_pop", obs0, mk(4, 0, 0, 0, 1, 0, 0, 8'h11));
    writeEn = 1'b1;
    readEn  = 1'b1;
    dataIn  = 8'h16;
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", obs0, mk(0, 0, 1, 0, 1, 0, 0, 8'h00));
    @(posedge clk);
    #1;
    checkOutput("reset_held", obs0, mk(0, 0, 1, 0, 1, 0, 0, 8'h00));
    writeEn = 1'b0;
    readEn  = 1'b0;
    reset   = 1'b0;

    // Fill, overflow, drain, underflow table
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b1, 1'b0, 8'(i),
                       mk(i + 1, i == 15, 0, (i + 1) >= 12, (i + 1) <= 4, 0, 0, 8'h00)});
    vecs.push_back('{1'b1, 1'b0, 8'h10, mk(16, 1, 0, 1, 0, 1, 0, 8'h00)});
    for (int i = 0; i < 16; i++)
      vecs.push_back('{1'b0, 1'b1, 8'h00,
                       mk(15 - i, 0, (15 - i) == 0, (15 - i) >= 12, (15 - i) <= 4, 0, 0, 8'(i))});
    vecs.push_back('{1'b0, 1'b1, 8'h00, mk(0, 0, 1, 0, 1, 0, 1, 8'h0F)});
    vecs.push_back('{1'b0, 1'b0, 8'h00, mk(0, 0, 1, 0, 1, 0, 0, 8'h0F)});
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].we, vecs[i].re, vecs[i].din);
      checkOutput($sformatf("vec%0d", i), obs0, vecs[i].exp);
    end

    // Pointer wrap: ordering checked against a reference queue
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h30 + 8'(i));
      model.push_back(8'h30 + 8'(i));
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("wrapA_rd%0d", i), dout0, model.pop_front());
    end
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h40 + 8'(i));
      model.push_back(8'h40 + 8'(i));
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 8'h50 + 8'(i));
      checkOutput($sformatf("wrapB_rd%0d", i), dout0, model.pop_front());
      model.push_back(8'h50 + 8'(i));
    end
    checkOutput("wrap_mid_count", count0, 12);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      checkOutput($sformatf("wrapC_rd%0d", i), dout0, model.pop_front());
    end
    checkOutput("wrap_end", obs0, mk(0, 0, 1, 0, 1, 0, 0, 8'h57));

    // Simultaneous read/write at full, then at empty
    doReset();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 8'(i));
    applyStimulus(1'b1, 1'b1, 8'hAA);
    checkOutput("full_rw", obs0, mk(16, 1, 0, 1, 0, 0, 0, 8'h00));
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("full_rw_tail", obs0, mk(0, 0, 1, 0, 1, 0, 0, 8'hAA));
    applyStimulus(1'b1, 1'b1, 8'h77);
    checkOutput("empty_rw", obs0, mk(1, 0, 0, 0, 1, 0, 1, 8'hAA));
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("empty_rw_pop", obs0, mk(0, 0, 1, 0, 1, 0, 0, 8'h77));

    // First-word-fall-through head visibility
    doReset();
    checkOutput("fwft_reset", obs1, mk(0, 0, 1, 0, 1, 0, 0, 8'h00));
    applyStimulus(1'b1, 1'b0, 8'h55);
    checkOutput("fwft_show", obs1, mk(1, 0, 0, 0, 1, 0, 0, 8'h55));
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("fwft_hold", dout1, 8'h55);
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("fwft_pop", obs1, mk(0, 0, 1, 0, 1, 0, 0, 8'h00));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
